// File: rtl/maze_path_player_pkg.sv
// maze_pkg: shared move and player-state types for the maze path
// recorder/player (maze_path_player, maze_path_stack).
package maze_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } move_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RECORD = 3'd1,
        STORED = 3'd2,
        PLAY   = 3'd3,
        ERR    = 3'd4
    } player_state_t;

    function automatic int min1_clog2(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/maze_path_player_if.sv
// Solver/player bundle for maze_path_player.
// Adds the hold input when MAZE_PLAYER_HOLD_EN is defined.
interface maze_path_player_if #(
    parameter int DEPTH = 256
);
    import maze_pkg::*;

    localparam int LW = $clog2(DEPTH + 1);

    logic          Start;
    logic          rec_valid;
    move_t         rec_move;
    logic          rec_pop;
    logic          Done;
    logic          Fail;
    logic          Run;
`ifdef MAZE_PLAYER_HOLD_EN
    logic          hold;
`endif
    logic          play_valid;
    move_t         play_move;
    logic          play_last;
    logic          ready;
    logic          busy;
    logic          overflow;
    logic [LW-1:0] len;

`ifdef MAZE_PLAYER_HOLD_EN
    modport master (
        output Start, rec_valid, rec_move, rec_pop, Done, Fail, Run, hold,
        input  play_valid, play_move, play_last, ready, busy, overflow, len
    );
    modport slave (
        input  Start, rec_valid, rec_move, rec_pop, Done, Fail, Run, hold,
        output play_valid, play_move, play_last, ready, busy, overflow, len
    );
`else
    modport master (
        output Start, rec_valid, rec_move, rec_pop, Done, Fail, Run,
        input  play_valid, play_move, play_last, ready, busy, overflow, len
    );
    modport slave (
        input  Start, rec_valid, rec_move, rec_pop, Done, Fail, Run,
        output play_valid, play_move, play_last, ready, busy, overflow, len
    );
`endif

endinterface

// File: rtl/maze_path_stack.sv
// Path stack: push/pop/replace-top storage with a one-cycle read port.
// No control state beyond the length register.
module maze_path_stack
    import maze_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clr,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_repl,
    input  move_t                        i_wdata,
    input  logic [min1_clog2(DEPTH)-1:0] i_raddr,
    output move_t                        o_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   o_len
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = min1_clog2(DEPTH);
    localparam logic [LW-1:0] ONE = LW'(1);

    move_t         r_mem [DEPTH];
    move_t         r_rdata;
    logic [LW-1:0] r_len;
    logic [LW-1:0] w_widx;
    logic [AW-1:0] w_waddr;
    logic          w_we;

    // Replace targets the current top, push the slot above it.
    always_comb begin
        w_we    = i_push | i_repl;
        w_widx  = i_repl ? (r_len - ONE) : r_len;
        w_waddr = w_widx[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= UP;
            r_len   <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
            if (i_clr)       r_len <= '0;
            else if (i_push) r_len <= r_len + ONE;
            else if (i_pop)  r_len <= r_len - ONE;
        end
    end

    assign o_rdata = r_rdata;
    assign o_len   = r_len;

endmodule

// File: rtl/maze_path_player.sv
// Maze path recorder and paced replay sequencer.
// Optional replay pause input under MAZE_PLAYER_HOLD_EN.
module maze_path_player
    import maze_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int STEP_CYCLES = 4
) (
    input logic               clk,
    input logic               rst,
    maze_path_player_if.slave bus
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = min1_clog2(DEPTH);
    localparam int CW = min1_clog2(STEP_CYCLES);

    localparam logic [LW-1:0] ONE      = LW'(1);
    localparam logic [LW-1:0] FULL     = LW'(DEPTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] S_IDLE   = 3'(IDLE);
    localparam logic [2:0] S_RECORD = 3'(RECORD);
    localparam logic [2:0] S_STORED = 3'(STORED);
    localparam logic [2:0] S_PLAY   = 3'(PLAY);
    localparam logic [2:0] S_ERR    = 3'(ERR);

    logic [2:0]    r_state;
    logic [LW-1:0] r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_play_valid;
    move_t         r_play_move;
    logic          r_play_last;
    logic          r_overflow;

    logic          w_hold;
    logic [LW-1:0] w_len;
    move_t         w_rdata;
    logic          w_st_rec, w_st_sto, w_st_play;
    logic          w_rec, w_want_push, w_full;
    logic          w_push, w_pop, w_repl, w_ovf;
    logic          w_play, w_fin, w_emit, w_last;
    logic [LW-1:0] w_idx_nx, w_rd_idx;
    logic [AW-1:0] w_raddr;

`ifdef MAZE_PLAYER_HOLD_EN
    assign w_hold = bus.hold;
`else
    assign w_hold = 1'b0;
`endif

    always_comb begin
        w_st_rec    = (r_state == S_RECORD);
        w_st_sto    = (r_state == S_STORED);
        w_st_play   = (r_state == S_PLAY);
        w_rec       = w_st_rec & ~bus.Start;
        w_full      = (w_len == FULL);
        // Push+pop on an empty stack degrades to a plain push.
        w_want_push = bus.rec_valid & (~bus.rec_pop | (w_len == '0));
        w_ovf       = w_rec & w_want_push & w_full;
        w_push      = w_rec & w_want_push & ~w_full;
        w_repl      = w_rec & bus.rec_valid & bus.rec_pop & (w_len != '0);
        w_pop       = w_rec & ~bus.rec_valid & bus.rec_pop & (w_len != '0);
        w_play      = w_st_play & ~bus.Start;
        w_fin       = w_play & (r_idx == w_len);
        w_emit      = w_play & ~w_fin & ~w_hold & (r_cnt == '0);
        w_idx_nx    = r_idx + ONE;
        w_last      = w_emit & (w_idx_nx == w_len);
        // Prefetch the next entry during an emit so rdata is ready in time.
        w_rd_idx    = w_emit ? w_idx_nx : r_idx;
        w_raddr     = (w_rd_idx < FULL) ? w_rd_idx[AW-1:0] : '0;
    end

    maze_path_stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (bus.Start),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_repl  (w_repl),
        .i_wdata (bus.rec_move),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata),
        .o_len   (w_len)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_play_valid <= 1'b0;
            r_play_move  <= UP;
            r_play_last  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_play_valid <= w_emit;
            r_play_last  <= w_last;
            if (w_emit) r_play_move <= w_rdata;
            if (bus.Start) begin
                r_state    <= S_RECORD;
                r_overflow <= 1'b0;
                r_idx      <= '0;
                r_cnt      <= '0;
            end else begin
                unique case (1'b1)
                    w_st_rec: begin
                        if (w_ovf) begin
                            r_overflow <= 1'b1;
                            r_state    <= S_ERR;
                        end else if (bus.Fail) begin
                            r_state <= S_ERR;
                        end else if (bus.Done) begin
                            r_state <= S_STORED;
                        end
                    end
                    w_st_sto: begin
                        if (bus.Run && (w_len != '0)) begin
                            r_state <= S_PLAY;
                            r_idx   <= '0;
                            r_cnt   <= '0;
                        end
                    end
                    w_st_play: begin
                        if (w_fin) begin
                            r_state <= S_STORED;
                            r_idx   <= '0;
                        end else if (w_emit) begin
                            r_idx <= w_idx_nx;
                            r_cnt <= CNT_LOAD;
                        end else if (!w_hold && (r_cnt != '0)) begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.play_valid = r_play_valid;
    assign bus.play_move  = r_play_move;
    assign bus.play_last  = r_play_last;
    assign bus.ready      = w_st_sto;
    assign bus.busy       = w_st_rec | w_st_play;
    assign bus.overflow   = r_overflow;
    assign bus.len        = w_len;

endmodule
